// File: rtl/ysyx_22050019_bus_pkg.sv
// Shared encodings for the memory read arbiter: FSM states, owner ids and
// AXI response codes.
package ysyx_22050019_bus_pkg;

   localparam int unsigned STATE_W = 2;

   // Arbiter FSM states
   localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] S_AR   = 2'd1;
   localparam logic [STATE_W-1:0] S_R    = 2'd2;

   // Owner encoding; also the bit index of each master in req/grant vectors
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // AXI response status codes
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22050019_rr_arb2.sv
// Two-way round-robin grant logic.
// Ports:
//   req_i        request vector, bit 0 = icache, bit 1 = dcache
//   last_owner_i master granted most recently (OWN_I / OWN_D)
//   gnt_o        one-hot grant, all zero when nothing requests
module ysyx_22050019_rr_arb2
   import ysyx_22050019_bus_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_owner_i,
   output logic [1:0] gnt_o
);

   // On conflict the master that did not win last time takes the grant
   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (last_owner_i == OWN_D) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/ysyx_22050019_mem_arbiter.sv
// Two-master read arbiter: shares one single-beat AR/R memory port between the
// icache refill port (i_*) and the dcache refill/uncached-load port (d_*).
// One transaction outstanding at a time, round-robin on conflict, the R beat
// is routed back to the master that issued the AR.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_ar_*, i_r_*            icache request / response channels
//   d_ar_*, d_r_*            dcache request / response channels
//   m_ar_*, m_r_*            downstream memory request / response channels
module ysyx_22050019_mem_arbiter
   import ysyx_22050019_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  i_ar_valid,
   output logic                  i_ar_ready,
   input  logic [ADDR_WIDTH-1:0] i_ar_addr,
   output logic                  i_r_valid,
   input  logic                  i_r_ready,
   output logic [1:0]            i_r_resp,
   output logic [DATA_WIDTH-1:0] i_r_data,

   input  logic                  d_ar_valid,
   output logic                  d_ar_ready,
   input  logic [ADDR_WIDTH-1:0] d_ar_addr,
   output logic                  d_r_valid,
   input  logic                  d_r_ready,
   output logic [1:0]            d_r_resp,
   output logic [DATA_WIDTH-1:0] d_r_data,

   output logic                  m_ar_valid,
   input  logic                  m_ar_ready,
   output logic [ADDR_WIDTH-1:0] m_ar_addr,
   input  logic                  m_r_valid,
   output logic                  m_r_ready,
   input  logic [1:0]            m_r_resp,
   input  logic [DATA_WIDTH-1:0] m_r_data
);

   logic [STATE_W-1:0]    state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  last_owner_q, last_owner_d;
   logic                  ar_valid_q, ar_valid_d;
   logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;

   logic [1:0]            gnt;
   logic                  win;
   logic                  in_idle;
   logic                  in_r;

   ysyx_22050019_rr_arb2 u_rr_arb2 (
      .req_i        ({d_ar_valid, i_ar_valid}),
      .last_owner_i (last_owner_q),
      .gnt_o        (gnt)
   );

   // Gating with rst keeps every ready/valid low for the whole reset window,
   // not just from the clearing of the state register onwards.
   assign in_idle = rst && (state_q == S_IDLE);
   assign in_r    = rst && (state_q == S_R);
   assign win     = gnt[1] ? OWN_D : OWN_I;

   // Request acceptance
   assign i_ar_ready = in_idle && gnt[0];
   assign d_ar_ready = in_idle && gnt[1];

   // Response routing: data/resp fan out to both, only valid is steered
   assign i_r_valid = in_r && (owner_q == OWN_I) && m_r_valid;
   assign d_r_valid = in_r && (owner_q == OWN_D) && m_r_valid;
   assign m_r_ready = in_r && ((owner_q == OWN_D) ? d_r_ready : i_r_ready);
   assign i_r_data  = m_r_data;
   assign d_r_data  = m_r_data;
   assign i_r_resp  = m_r_resp;
   assign d_r_resp  = m_r_resp;

   assign m_ar_valid = ar_valid_q;
   assign m_ar_addr  = ar_addr_q;

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      ar_valid_d   = ar_valid_q;
      ar_addr_d    = ar_addr_q;
      unique case (state_q)
         S_IDLE: begin
            if (|gnt) begin
               owner_d      = win;
               last_owner_d = win;
               ar_valid_d   = 1'b1;
               ar_addr_d    = gnt[1] ? d_ar_addr : i_ar_addr;
               state_d      = S_AR;
            end
         end
         S_AR: begin
            if (m_ar_ready) begin
               ar_valid_d = 1'b0;
               state_d    = S_R;
            end
         end
         S_R: begin
            if (m_r_valid && m_r_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            ar_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State registers; reset leaves last_owner at D so I wins the first conflict
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         owner_q      <= OWN_I;
         last_owner_q <= OWN_D;
         ar_valid_q   <= 1'b0;
         ar_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         ar_valid_q   <= ar_valid_d;
         ar_addr_q    <= ar_addr_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22050019_mem_arbiter.sv
// Directed self-checking bench for ysyx_22050019_mem_arbiter.
module tb_ysyx_22050019_mem_arbiter;

   logic        clk;
   logic        rst;
   logic        i_ar_valid, i_ar_ready, i_r_valid, i_r_ready;
   logic [31:0] i_ar_addr;
   logic [1:0]  i_r_resp;
   logic [63:0] i_r_data;
   logic        d_ar_valid, d_ar_ready, d_r_valid, d_r_ready;
   logic [31:0] d_ar_addr;
   logic [1:0]  d_r_resp;
   logic [63:0] d_r_data;
   logic        m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
   logic [31:0] m_ar_addr;
   logic [1:0]  m_r_resp;
   logic [63:0] m_r_data;

   int n_total;
   int n_bad;

   ysyx_22050019_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_ar_valid (i_ar_valid),
      .i_ar_ready (i_ar_ready),
      .i_ar_addr  (i_ar_addr),
      .i_r_valid  (i_r_valid),
      .i_r_ready  (i_r_ready),
      .i_r_resp   (i_r_resp),
      .i_r_data   (i_r_data),
      .d_ar_valid (d_ar_valid),
      .d_ar_ready (d_ar_ready),
      .d_ar_addr  (d_ar_addr),
      .d_r_valid  (d_r_valid),
      .d_r_ready  (d_r_ready),
      .d_r_resp   (d_r_resp),
      .d_r_data   (d_r_data),
      .m_ar_valid (m_ar_valid),
      .m_ar_ready (m_ar_ready),
      .m_ar_addr  (m_ar_addr),
      .m_r_valid  (m_r_valid),
      .m_r_ready  (m_r_ready),
      .m_r_resp   (m_r_resp),
      .m_r_data   (m_r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // One full transaction with ar_valid levels already set by the caller
   task automatic serve(input logic exp_d, input logic [31:0] exp_addr,
                        input logic [63:0] data, input logic [1:0] resp);
      m_ar_ready = 1'b1;
      i_r_ready  = 1'b1;
      d_r_ready  = 1'b1;
      #1;
      chk("srv_i_ar_ready", 64'(i_ar_ready), 64'(!exp_d));
      chk("srv_d_ar_ready", 64'(d_ar_ready), 64'(exp_d));
      tick();
      chk("srv_m_ar_valid", 64'(m_ar_valid), 64'd1);
      chk("srv_m_ar_addr", 64'(m_ar_addr), 64'(exp_addr));
      chk("srv_ar_ready_busy", 64'({i_ar_ready, d_ar_ready}), 64'd0);
      tick();
      chk("srv_m_ar_valid_drop", 64'(m_ar_valid), 64'd0);
      m_r_valid = 1'b1;
      m_r_data  = data;
      m_r_resp  = resp;
      #1;
      chk("srv_i_r_valid", 64'(i_r_valid), 64'(!exp_d));
      chk("srv_d_r_valid", 64'(d_r_valid), 64'(exp_d));
      chk("srv_r_data", exp_d ? d_r_data : i_r_data, data);
      chk("srv_r_resp", 64'(exp_d ? d_r_resp : i_r_resp), 64'(resp));
      chk("srv_m_r_ready", 64'(m_r_ready), 64'd1);
      tick();
      m_r_valid = 1'b0;
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      rst        = 1'b0;
      i_ar_valid = 1'b1;
      i_ar_addr  = 32'h0;
      i_r_ready  = 1'b0;
      d_ar_valid = 1'b0;
      d_ar_addr  = 32'h0;
      d_r_ready  = 1'b0;
      m_ar_ready = 1'b0;
      m_r_valid  = 1'b0;
      m_r_resp   = 2'b00;
      m_r_data   = 64'h0;

      // Reset state, including requests suppressed while in reset
      tick();
      chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
      chk("rst_m_ar_addr", 64'(m_ar_addr), 64'd0);
      chk("rst_i_ar_ready", 64'(i_ar_ready), 64'd0);
      chk("rst_r_valid", 64'({i_r_valid, d_r_valid, m_r_ready}), 64'd0);
      i_ar_valid = 1'b0;
      tick();
      rst = 1'b1;

      // Lone icache request
      i_ar_valid = 1'b1;
      i_ar_addr  = 32'h8000_0010;
      m_ar_ready = 1'b1;
      #1;
      chk("t1_i_ar_ready", 64'(i_ar_ready), 64'd1);
      chk("t1_d_ar_ready", 64'(d_ar_ready), 64'd0);
      tick();
      i_ar_valid = 1'b0;
      chk("t1_m_ar_valid", 64'(m_ar_valid), 64'd1);
      chk("t1_m_ar_addr", 64'(m_ar_addr), 64'h8000_0010);
      tick();
      m_r_valid = 1'b1;
      m_r_data  = 64'h1122_3344_5566_7788;
      m_r_resp  = 2'b00;
      i_r_ready = 1'b1;
      #1;
      chk("t1_i_r_valid", 64'(i_r_valid), 64'd1);
      chk("t1_i_r_data", i_r_data, 64'h1122_3344_5566_7788);
      chk("t1_d_r_valid", 64'(d_r_valid), 64'd0);
      tick();
      m_r_valid = 1'b0;
      chk("t1_idle_i_r_valid", 64'(i_r_valid), 64'd0);

      // Both requesting from reset: strict alternation starting with I
      do_reset();
      i_ar_valid = 1'b1;
      i_ar_addr  = 32'h0000_1000;
      d_ar_valid = 1'b1;
      d_ar_addr  = 32'h0000_2000;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) serve(1'b0, 32'h0000_1000, 64'hA0 + 64'(k), 2'b00);
         else            serve(1'b1, 32'h0000_2000, 64'hB0 + 64'(k), 2'b00);
      end
      i_ar_valid = 1'b0;

      // AR back-pressure on a dcache request, then R back-pressure by D
      d_ar_addr  = 32'h2000_0040;
      m_ar_ready = 1'b0;
      #1;
      chk("t3_d_ar_ready", 64'(d_ar_ready), 64'd1);
      tick();
      for (int k = 0; k < 6; k++) begin
         if (k == 5) m_ar_ready = 1'b1;
         #1;
         chk("t3_m_ar_valid", 64'(m_ar_valid), 64'd1);
         chk("t3_m_ar_addr", 64'(m_ar_addr), 64'h2000_0040);
         chk("t3_d_ar_ready_busy", 64'(d_ar_ready), 64'd0);
         tick();
      end
      d_ar_valid = 1'b0;
      m_r_valid  = 1'b1;
      m_r_data   = 64'hDEAD_BEEF_0000_0001;
      m_r_resp   = 2'b00;
      d_r_ready  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t4_m_r_ready_stall", 64'(m_r_ready), 64'd0);
         chk("t4_d_r_valid_stall", 64'(d_r_valid), 64'd1);
         tick();
      end
      d_r_ready = 1'b1;
      #1;
      chk("t4_m_r_ready", 64'(m_r_ready), 64'd1);
      chk("t4_d_r_data", d_r_data, 64'hDEAD_BEEF_0000_0001);
      tick();
      m_r_valid = 1'b0;
      #1;
      chk("t4_d_r_valid_done", 64'(d_r_valid), 64'd0);

      // SLVERR forwarded to icache; idle afterwards with no retry
      i_ar_valid = 1'b1;
      i_ar_addr  = 32'h8000_0100;
      serve(1'b0, 32'h8000_0100, 64'h5555_AAAA_5555_AAAA, 2'b10);
      i_ar_valid = 1'b0;
      tick();
      chk("t5_no_retry", 64'(m_ar_valid), 64'd0);

      // Reset asserted in S_R clears routing in the same cycle
      i_ar_valid = 1'b1;
      i_ar_addr  = 32'h8000_0200;
      m_ar_ready = 1'b1;
      tick();
      i_ar_valid = 1'b0;
      tick();
      m_r_valid = 1'b1;
      i_r_ready = 1'b1;
      #1;
      chk("t6_pre_i_r_valid", 64'(i_r_valid), 64'd1);
      rst = 1'b0;
      #1;
      chk("t6_rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
      chk("t6_rst_r_valid", 64'({i_r_valid, d_r_valid}), 64'd0);
      chk("t6_rst_m_r_ready", 64'(m_r_ready), 64'd0);
      tick();
      m_r_valid = 1'b0;
      rst = 1'b1;
      d_ar_valid = 1'b1;
      d_ar_addr  = 32'h3000_0008;
      serve(1'b1, 32'h3000_0008, 64'h0123_4567_89AB_CDEF, 2'b00);
      d_ar_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/ysyx_22050019_mem_arbiter.md
Name: ysyx_22050019_mem_arbiter

Overview:
Two-master read arbiter sharing the single downstream memory read port between the icache refill port and the dcache refill/uncached-load port.
- Serialises single-beat AR/R transactions, one outstanding at a time.
- Round-robin on conflict.
- Routes the R beat back to the master that issued the AR.
- Sits between the two caches' miss ports and the AXI-lite memory/bridge.

Parameters:
ADDR_WIDTH, 32, address width on all AR channels
DATA_WIDTH, 64, R data width on all channels

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
i_ar_valid  in  1  icache read request
i_ar_ready  out  1  icache request accepted
i_ar_addr  in  ADDR_WIDTH  icache request address
i_r_valid  out  1  icache response valid
i_r_ready  in  1  icache response ready
i_r_resp  out  2  icache response status
i_r_data  out  DATA_WIDTH  icache response data
d_ar_valid  in  1  dcache read request
d_ar_ready  out  1  dcache request accepted
d_ar_addr  in  ADDR_WIDTH  dcache request address
d_r_valid  out  1  dcache response valid
d_r_ready  in  1  dcache response ready
d_r_resp  out  2  dcache response status
d_r_data  out  DATA_WIDTH  dcache response data
m_ar_valid  out  1  memory read request
m_ar_ready  in  1  memory accepts request
m_ar_addr  out  ADDR_WIDTH  memory request address
m_r_valid  in  1  memory response valid
m_r_ready  out  1  arbiter accepts response
m_r_resp  in  2  memory response status
m_r_data  in  DATA_WIDTH  memory response data

Behaviour:
- Reset (rst low, asynchronous, any state including mid-transaction):
  - state=S_IDLE, m_ar_valid=0, m_ar_addr=0, owner=I, last_owner=D.
  - All x_ar_ready, x_r_valid and m_r_ready are 0.
  - Any in-flight memory transaction is abandoned; no beat is forwarded after reset.
- States: S_IDLE, S_AR, S_R. All registers are clocked; only the ready/valid routing listed below is combinational.
- S_IDLE arbitration (combinational):
  - Only i_ar_valid high: grant I. Only d_ar_valid high: grant D.
  - Both high: grant the master != last_owner.
- S_IDLE accept cycle:
  - Winner's x_ar_ready=1 in the same cycle; the loser's ready stays 0.
  - Registered on that edge: owner<=winner, last_owner<=winner, m_ar_addr<=winner addr (unmodified), m_ar_valid<=1, state<=S_AR.
  - x_ar_ready is 0 in all other states.
- S_AR:
  - Hold m_ar_valid and m_ar_addr stable until m_ar_ready.
  - On handshake: m_ar_valid<=0, state<=S_R. m_ar_ready already high on the first m_ar_valid cycle is legal (one-cycle S_AR).
- S_R (combinational routing):
  - owner's x_r_valid=m_r_valid; non-owner's x_r_valid=0.
  - m_r_ready=owner's x_r_ready.
  - i_r_data/d_r_data=m_r_data and i_r_resp/d_r_resp=m_r_resp on both masters always; only valid is gated.
  - On m_r_valid&m_r_ready: state<=S_IDLE. Single beat only.
- Response status (resp) is forwarded unchanged, including SLVERR/DECERR.
- Owner back-pressure (x_r_ready low) stalls memory indefinitely. No timeout.
- Minimum turnaround: accept at cycle 0, m_ar_valid at cycle 1, next grant no earlier than the cycle after the R handshake.
- A request raised while busy waits. Masters must hold x_ar_valid and x_ar_addr until ready; the arbiter relies on this.
- No starvation: with both masters continuously requesting, grants strictly alternate.

Decomposition:
- Shared package ysyx_22050019_bus_pkg holds:
  - state encodings S_IDLE/S_AR/S_R.
  - owner encoding OWN_I=0/OWN_D=1.
  - AXI resp constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- One natural sub-module: ysyx_22050019_rr_arb2, the 2-way round-robin grant logic taking req[1:0] and last_owner and returning a one-hot grant. The FSM and routing stay in the top module.

Test Plan:
- Only i_ar_valid, addr 0x8000_0010; m_ar_ready=1, m_r_valid one cycle later with data 0x1122334455667788, resp 0 -> i_ar_ready at cycle 0; m_ar_addr 0x8000_0010 at cycle 1; i_r_valid with that data; d_r_valid stays 0.
- i and d request together from reset -> I granted first (last_owner=D). D granted immediately after I's R completes. Then both request continuously for 4 grants -> order I,D,I,D.
- m_ar_ready held low 5 cycles -> m_ar_valid and m_ar_addr stable for all 6 cycles; d_ar_ready stays 0 while D requests.
- Owner D holds d_r_ready low 3 cycles with m_r_valid high -> m_r_ready=0 for those cycles; beat delivered on cycle 4; state returns to S_IDLE.
- m_r_resp=2'b10 on an I transaction -> i_r_resp=2'b10, same beat, no retry.
- rst asserted low during S_R -> same-cycle async clear: m_ar_valid=0, i_r_valid=d_r_valid=0. After release, a new D request is granted normally.
